pwm_bank_reg: RTL and testbench
===============================

Name: pwm_bank_reg

Overview:
- Parametrised successor to the fixed 8-channel bus-mapped PWM register block.
- Bus slave on the existing cs/addr/rd/wr/d_in/d_out peripheral bus.
- Drives NCH independent PWM outputs, each with CW-bit period and duty counters.
- Adds over the previous generation: double-buffered (shadow) period/duty loaded glitch-free at period wrap, per-channel output polarity, counter read-back, global synchronous restart, and registered read data.

Parameters:
- NCH, 8, number of PWM channels (1..15).
- CW, 32, counter/period/duty width in bits (1..32).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- cs  in  1  chip select.
- addr  in  8  byte address; bits [1:0] ignored.
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- d_in  in  32  write data.
- d_out  out  32  registered read data.
- pwm  out  NCH  PWM outputs, bit i = channel i.

Behaviour:
- Reset: when rst_n=0 at a clk edge, the following clear to 0: all CTRL, shadow and active PERIOD/DUTY, counters, d_out and pwm.
- Register map, per channel i at base 16*i:
  - +0x0 CTRL (RW): bit0 EN, bit1 POL; other bits read 0.
  - +0x4 PERIOD shadow (RW, CW bits).
  - +0x8 DUTY shadow (RW, CW bits).
  - +0xC COUNT (RO, current counter).
- Global registers:
  - 0xF0 SYNC (WO): each 1 in bit i restarts channel i. Reads 0.
  - 0xF4 INFO (RO): {16'h0, NCH[7:0], CW[7:0]}.
- Unmapped addresses, and channels at or above NCH, read 0; writes to them are ignored.
- Write: occurs at an edge with cs=1, wr=1, rd=0. Register takes d_in[CW-1:0]; upper bits are dropped. Writes to COUNT and INFO are ignored.
- Read: at an edge with cs=1, rd=1, wr=0, d_out is loaded with the addressed value, zero-extended. Data is valid the cycle after the strobe (1-cycle latency).
- d_out holds its value when there is no read. wr=1 together with rd=1 is illegal: no write occurs and d_out holds.
- Channel with EN=0:
  - counter held at 0;
  - active PERIOD/DUTY copy the shadows every cycle;
  - pwm[i] is registered to POL (idle level).
- Channel with EN=1:
  - If active period P=0: counter held at 0, pwm[i]=POL, and active copies the shadows each cycle so a later nonzero write takes effect.
  - Otherwise the counter counts 0..P-1.
  - In the cycle where counter==P-1: next counter=0, and active PERIOD/DUTY load from the shadows (wrap load).
- Shadow writes made mid-period never change the current period.
- Output: pwm[i] <= (counter < active DUTY) XOR POL, registered, so it trails COUNT by 1 cycle.
  - DUTY=0 gives constant POL.
  - DUTY>=P gives constant ~POL.
- EN 0->1 write: counting begins at 0 on the next edge, using the shadow values present at that write.
- SYNC write on bit i:
  - at that edge, counter forced to 0 and active loaded from shadows;
  - SYNC has priority over wrap and over a simultaneous shadow write to the same channel (the shadow takes the new value, active takes the old shadow);
  - has no effect when EN=0.
- CTRL write clearing EN mid-period: takes effect at that edge (counter to 0, pwm to POL on the next edge).
- Reset asserted mid-operation overrides every other event.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with activity on all strobes -> pwm=0, d_out=0; reading any CTRL/PERIOD/DUTY/COUNT returns 0.
- Basic PWM, ch0: PERIOD=10, DUTY=3, CTRL=1 -> pwm[0] is high 3 cycles and low 7, repeating with period 10. COUNT read returns 0..9 with d_out one cycle after rd.
- Shadow update: while running as above, write DUTY=7 at counter=4 -> current period keeps 3-high. From the next counter=0 the output is 7-high/3-low.
- Boundaries: DUTY=0 -> constant 0. DUTY=12 with PERIOD=10 -> constant 1. PERIOD=0 with EN=1 -> constant POL and COUNT=0. POL=1 with DUTY=3 -> inverted waveform (3 low, 7 high).
- SYNC: ch1 and ch2 running at PERIOD=8 with different phases; write SYNC=0x6 -> both COUNT values are 0 the cycle after and stay aligned. ch0 (EN=0) is unaffected.
- Bus corners:
  - read 0xF4 with NCH=8, CW=32 -> 0x00000820;
  - read 0xE8 -> 0;
  - wr=rd=1 to PERIOD of ch0 -> no change and d_out unchanged;
  - CW=8 build, write PERIOD=0x1FF -> read back 0xFF.

Source files
------------

// File: rtl/pwm_bank_reg.sv
// Bank of NCH bus-mapped PWM channels. Each channel has shadow period/duty registers
// that move into the active copies at period wrap, on SYNC, or while the channel is idle.
module pwm_bank_reg #(
    parameter int NCH = 8,
    parameter int CW  = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cs,
    input  logic [7:0]     addr,
    input  logic           rd,
    input  logic           wr,
    input  logic [31:0]    d_in,
    output logic [31:0]    d_out,
    output logic [NCH-1:0] pwm
);

    logic           wr_en;
    logic           rd_en;
    logic [3:0]     chan;
    logic [1:0]     sel;
    logic           is_global;
    logic           addr_unused;

    logic [NCH-1:0] en_q, en_d;
    logic [NCH-1:0] pol_q, pol_d;
    logic [NCH-1:0] pwm_q, pwm_d;
    logic [NCH-1:0] ch_wr;
    logic [NCH-1:0] sync_hit;
    logic [NCH-1:0] run;

    logic [CW-1:0]  per_sh_q   [NCH];
    logic [CW-1:0]  per_sh_d   [NCH];
    logic [CW-1:0]  duty_sh_q  [NCH];
    logic [CW-1:0]  duty_sh_d  [NCH];
    logic [CW-1:0]  per_act_q  [NCH];
    logic [CW-1:0]  per_act_d  [NCH];
    logic [CW-1:0]  duty_act_q [NCH];
    logic [CW-1:0]  duty_act_d [NCH];
    logic [CW-1:0]  cnt_q      [NCH];
    logic [CW-1:0]  cnt_d      [NCH];

    logic [31:0]    rd_val;
    logic [31:0]    d_out_q, d_out_d;

    // A simultaneous read and write strobe is treated as no access at all.
    assign wr_en       = cs && wr && !rd;
    assign rd_en       = cs && rd && !wr;
    assign chan        = addr[7:4];
    assign sel         = addr[3:2];
    assign is_global   = (chan == 4'hF);
    assign addr_unused = ^addr[1:0];

    always_comb begin
        ch_wr    = '0;
        sync_hit = '0;
        run      = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_wr[i]    = wr_en && (chan == 4'(i));
            sync_hit[i] = wr_en && is_global && (sel == 2'd0) && d_in[i];
            // Clearing EN stops the counter at the very edge of the CTRL write.
            run[i]      = en_q[i] && !(ch_wr[i] && (sel == 2'd0) && !d_in[0]);
        end
    end

    always_comb begin
        en_d  = en_q;
        pol_d = pol_q;
        pwm_d = pwm_q;
        for (int i = 0; i < NCH; i++) begin
            per_sh_d[i]   = per_sh_q[i];
            duty_sh_d[i]  = duty_sh_q[i];
            per_act_d[i]  = per_act_q[i];
            duty_act_d[i] = duty_act_q[i];
            cnt_d[i]      = cnt_q[i];

            if (ch_wr[i]) begin
                case (sel)
                    2'd0: begin
                        en_d[i]  = d_in[0];
                        pol_d[i] = d_in[1];
                    end
                    2'd1:    per_sh_d[i]  = d_in[CW-1:0];
                    2'd2:    duty_sh_d[i] = d_in[CW-1:0];
                    default: ;
                endcase
            end

            // Active copies read the old shadow values, so a same-edge shadow write waits a period.
            if (!run[i] || sync_hit[i] || (per_act_q[i] == '0) ||
                (cnt_q[i] == per_act_q[i] - CW'(1))) begin
                cnt_d[i]      = '0;
                per_act_d[i]  = per_sh_q[i];
                duty_act_d[i] = duty_sh_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end

            if (!en_q[i] || (per_act_q[i] == '0))
                pwm_d[i] = pol_q[i];
            else
                pwm_d[i] = (cnt_q[i] < duty_act_q[i]) ^ pol_q[i];
        end
    end

    always_comb begin
        rd_val = '0;
        if (is_global) begin
            if (sel == 2'd1)
                rd_val = {16'h0, 8'(NCH), 8'(CW)};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (chan == 4'(i)) begin
                    case (sel)
                        2'd0:    rd_val[1:0]    = {pol_q[i], en_q[i]};
                        2'd1:    rd_val[CW-1:0] = per_sh_q[i];
                        2'd2:    rd_val[CW-1:0] = duty_sh_q[i];
                        default: rd_val[CW-1:0] = cnt_q[i];
                    endcase
                end
            end
        end
        d_out_d = rd_en ? rd_val : d_out_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q    <= '0;
            pol_q   <= '0;
            pwm_q   <= '0;
            d_out_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                per_sh_q[i]   <= '0;
                duty_sh_q[i]  <= '0;
                per_act_q[i]  <= '0;
                duty_act_q[i] <= '0;
                cnt_q[i]      <= '0;
            end
        end else begin
            en_q       <= en_d;
            pol_q      <= pol_d;
            pwm_q      <= pwm_d;
            d_out_q    <= d_out_d;
            per_sh_q   <= per_sh_d;
            duty_sh_q  <= duty_sh_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            cnt_q      <= cnt_d;
        end
    end

    assign d_out = d_out_q;
    assign pwm   = pwm_q;

endmodule

// File: tb/tb_pwm_bank_reg.sv
// Directed bench for pwm_bank_reg: a full-width bank and a CW=8 bank share one bus.
module tb_pwm_bank_reg;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs    = 1'b0;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic [7:0]  addr  = 8'h00;
    logic [31:0] d_in  = 32'h0;
    logic [31:0] d_out;
    logic [31:0] d_out8;
    logic [7:0]  pwm;
    logic [7:0]  pwm8;

    int checks = 0;
    int errors = 0;

    pwm_bank_reg #(.NCH(8), .CW(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_in(d_in), .d_out(d_out), .pwm(pwm)
    );

    pwm_bank_reg #(.NCH(8), .CW(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_in(d_in), .d_out(d_out8), .pwm(pwm8)
    );

    always #5 clk = ~clk;

    // Bus tasks are entered on a falling edge and return on the falling edge after the access.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] data);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        data = d_out;
    endtask

    task automatic test_reset();
        logic [7:0]  addrs [5];
        logic [31:0] data;
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h3C};
        rst_n = 1'b0;
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 8'h00; d_in = 32'h3;
        @(negedge clk);
        wr = 1'b0; rd = 1'b1;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; rst_n = 1'b1;
        checks++;
        if (pwm !== 8'h00) begin errors++; $display("[TB] FAIL reset_pwm: got %0h expected 0", pwm); end
        checks++;
        if (d_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_dout: got %0h expected 0", d_out); end
        checks++;
        if (pwm8 !== 8'h00 || d_out8 !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_cw8: got pwm %0h dout %0h expected 0/0", pwm8, d_out8);
        end
        for (int i = 0; i < 5; i++) begin
            bus_read(addrs[i], data);
            checks++;
            if (data !== 32'h0) begin
                errors++; $display("[TB] FAIL reset_read_%0h: got %0h expected 0", addrs[i], data);
            end
        end
    endtask

    task automatic test_basic();
        bus_write(8'h04, 32'd10);
        bus_write(8'h08, 32'd3);
        bus_write(8'h00, 32'h1);
        bus_write(8'hF0, 32'h1);
        cs = 1'b1; rd = 1'b1; addr = 8'h0C;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (d_out !== 32'((k - 1) % 10)) begin
                errors++; $display("[TB] FAIL basic_count k=%0d: got %0d expected %0d", k, d_out, (k - 1) % 10);
            end
            checks++;
            if (pwm[0] !== (((k - 1) % 10) < 3)) begin
                errors++; $display("[TB] FAIL basic_pwm k=%0d: got %b expected %b", k, pwm[0], ((k - 1) % 10) < 3);
            end
        end
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic test_shadow();
        logic expv;
        bus_write(8'hF0, 32'h1);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 5) begin cs = 1'b0; wr = 1'b0; end
            expv = (k <= 10) ? (((k - 1) % 10) < 3) : (((k - 1) % 10) < 7);
            checks++;
            if (pwm[0] !== expv) begin
                errors++; $display("[TB] FAIL shadow_pwm k=%0d: got %b expected %b", k, pwm[0], expv);
            end
            if (k == 4) begin
                cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 8'h08; d_in = 32'd7;
            end
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] data;
        logic        expv;
        bus_write(8'h08, 32'd0);
        bus_write(8'hF0, 32'h1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (pwm[0] !== 1'b0) begin errors++; $display("[TB] FAIL duty0 k=%0d: got %b expected 0", k, pwm[0]); end
        end
        bus_write(8'h08, 32'd12);
        bus_write(8'hF0, 32'h1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (pwm[0] !== 1'b1) begin errors++; $display("[TB] FAIL duty12 k=%0d: got %b expected 1", k, pwm[0]); end
        end
        bus_write(8'h04, 32'd0);
        bus_write(8'hF0, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (pwm[0] !== 1'b0) begin errors++; $display("[TB] FAIL period0 k=%0d: got %b expected 0", k, pwm[0]); end
        end
        bus_read(8'h0C, data);
        checks++;
        if (data !== 32'h0) begin errors++; $display("[TB] FAIL period0_count: got %0d expected 0", data); end
        bus_write(8'h04, 32'd10);
        bus_write(8'h08, 32'd3);
        bus_write(8'h00, 32'h3);
        bus_write(8'hF0, 32'h1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            expv = !(((k - 1) % 10) < 3);
            checks++;
            if (pwm[0] !== expv) begin
                errors++; $display("[TB] FAIL pol_pwm k=%0d: got %b expected %b", k, pwm[0], expv);
            end
        end
        bus_write(8'h00, 32'h0);
    endtask

    task automatic test_sync();
        logic [7:0]  raddr [5];
        logic [31:0] rexp  [5];
        logic [31:0] data;
        logic        expv;
        raddr = '{8'h1C, 8'h2C, 8'h1C, 8'h2C, 8'h0C};
        rexp  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        bus_write(8'h14, 32'd8);
        bus_write(8'h18, 32'd4);
        bus_write(8'h24, 32'd8);
        bus_write(8'h28, 32'd4);
        bus_write(8'h10, 32'h1);
        repeat (3) @(negedge clk);
        bus_write(8'h20, 32'h1);
        repeat (2) @(negedge clk);
        bus_write(8'hF0, 32'h6);
        for (int r = 0; r < 5; r++) begin
            bus_read(raddr[r], data);
            checks++;
            if (data !== rexp[r]) begin
                errors++; $display("[TB] FAIL sync_count_%0h: got %0d expected %0d", raddr[r], data, rexp[r]);
            end
        end
        for (int k = 6; k <= 21; k++) begin
            @(negedge clk);
            expv = ((k - 1) % 8) < 4;
            checks++;
            if (pwm[2:0] !== {expv, expv, 1'b0}) begin
                errors++; $display("[TB] FAIL sync_pwm k=%0d: got %b expected %b", k, pwm[2:0], {expv, expv, 1'b0});
            end
        end
    endtask

    task automatic test_bus();
        logic [31:0] data;
        bus_read(8'hF4, data);
        checks++;
        if (data !== 32'h00000820) begin errors++; $display("[TB] FAIL info: got %0h expected 820", data); end
        checks++;
        if (d_out8 !== 32'h00000808) begin errors++; $display("[TB] FAIL info_cw8: got %0h expected 808", d_out8); end
        bus_read(8'hE8, data);
        checks++;
        if (data !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_e8: got %0h expected 0", data); end
        bus_read(8'hF4, data);
        cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 8'h04; d_in = 32'h55;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        checks++;
        if (d_out !== 32'h00000820) begin errors++; $display("[TB] FAIL wr_rd_dout: got %0h expected 820", d_out); end
        bus_read(8'h04, data);
        checks++;
        if (data !== 32'd10) begin errors++; $display("[TB] FAIL wr_rd_period: got %0h expected a", data); end
        bus_write(8'h04, 32'h1FF);
        bus_read(8'h04, data);
        checks++;
        if (data !== 32'h1FF) begin errors++; $display("[TB] FAIL period_cw32: got %0h expected 1ff", data); end
        checks++;
        if (d_out8 !== 32'hFF) begin errors++; $display("[TB] FAIL period_cw8: got %0h expected ff", d_out8); end
        bus_write(8'hF4, 32'h1234);
        bus_read(8'hF4, data);
        checks++;
        if (data !== 32'h00000820) begin errors++; $display("[TB] FAIL info_write: got %0h expected 820", data); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] data;
        rst_n = 1'b0;
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 8'h14; d_in = 32'd3;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; rst_n = 1'b1;
        checks++;
        if (pwm !== 8'h00 || d_out !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_mid: got pwm %0h dout %0h expected 0/0", pwm, d_out);
        end
        bus_read(8'h14, data);
        checks++;
        if (data !== 32'h0) begin errors++; $display("[TB] FAIL reset_mid_period: got %0h expected 0", data); end
        bus_read(8'h10, data);
        checks++;
        if (data !== 32'h0) begin errors++; $display("[TB] FAIL reset_mid_ctrl: got %0h expected 0", data); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_shadow();
        test_boundaries();
        test_sync();
        test_bus();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
